// File: rtl/uart_tx_buffer_pkg.sv
// Shared UART header: UART register map, LSR bit positions, CPU-side offsets and FSM encodings.
// Used by uart_tx_buffer and uart_txbuf_fifo.
package uart_tx_buffer_pkg;

    localparam logic [2:0] OFF_UART_DATA   = 3'd0;
    localparam logic [2:0] OFF_UART_LSR    = 3'd5;
    localparam int         LSR_TX_IDLE_BIT = 5;

    localparam logic [1:0] OFF_TX_DATA = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_IRQ_EN  = 2'd2;
    localparam logic [1:0] OFF_RSVD    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_POLL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_GUARD = 2'd3
    } txbuf_state_e;

    function automatic logic [31:0] pack_status(input logic [8:0] cnt, input logic full,
                                                input logic empty, input logic ovf);
        return {20'b0, cnt, full, empty, ovf};
    endfunction

endpackage

// File: rtl/uart_txbuf_fifo.sv
// Byte FIFO of 2**DEPTH_LOG2 entries; push/pop take effect on the clock edge, head is combinational.
// A push while full is refused, a pop while empty is refused.
module uart_txbuf_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  push_i,
    input  logic [7:0]            push_dat_i,
    input  logic                  pop_i,
    output logic [7:0]            head_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  push_ok, pop_ok;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Full/empty are judged on the count at cycle start, so a pop never makes room for a same-cycle push.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// CPU-side transmit buffer that drains bytes into a UART by polling LSR tx-idle, writing DATA, then idling GUARD_CYC cycles.
// CPU accesses ack in the same cycle; macro UART_TXBUF_IRQ_EN adds the registered FIFO-empty interrupt.
module uart_tx_buffer
    import uart_tx_buffer_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int GUARD_CYC  = 2
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [3:2]  ADD_I,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    input  logic        STB_I,
    input  logic        WE_I,
    output logic        ACK_O,
    output logic [4:2]  U_ADD_O,
    output logic [31:0] U_DAT_O,
    input  logic [31:0] U_DAT_I,
    output logic        U_STB_O,
    output logic        U_WE_O,
    input  logic        U_ACK_I,
    output logic        IRQ_O
);
    localparam logic [3:0] GUARD_LAST = 4'(GUARD_CYC - 1);

    txbuf_state_e        state_q, state_d;
    logic [3:0]          guard_q, guard_d;
    logic                overflow_q, overflow_d;
    logic                cpu_wr, push, pop;
    logic [7:0]          head;
    logic [DEPTH_LOG2:0] fifo_count;
    logic [8:0]          cnt9;
    logic                fifo_full, fifo_empty;
    logic                irq_en_rd;
    logic                unused_bits;

    assign unused_bits = ^{DAT_I[31:8], U_DAT_I};

    assign ACK_O  = STB_I;
    assign cpu_wr = STB_I & WE_I;
    assign push   = cpu_wr & (ADD_I == OFF_TX_DATA);
    assign pop    = (state_q == ST_WRITE) & U_ACK_I;

    uart_txbuf_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .CLK_I      (CLK_I),
        .RST_I      (RST_I),
        .push_i     (push),
        .push_dat_i (DAT_I[7:0]),
        .pop_i      (pop),
        .head_o     (head),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_comb begin
        cnt9 = '0;
        cnt9[DEPTH_LOG2:0] = fifo_count;
    end

    always_comb begin
        overflow_d = overflow_q;
        if (push && fifo_full)
            overflow_d = 1'b1;
        else if (cpu_wr && ADD_I == OFF_STATUS && DAT_I[0])
            overflow_d = 1'b0;
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) overflow_q <= 1'b0;
        else       overflow_q <= overflow_d;
    end

`ifdef UART_TXBUF_IRQ_EN
    logic irq_en_q, irq_q;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (cpu_wr && ADD_I == OFF_IRQ_EN) irq_en_q <= DAT_I[0];
            irq_q <= fifo_empty & irq_en_q;
        end
    end

    assign irq_en_rd = irq_en_q;
    assign IRQ_O     = irq_q;
`else
    assign irq_en_rd = 1'b0;
    assign IRQ_O     = 1'b0;
`endif

    always_comb begin
        DAT_O = '0;
        case (ADD_I)
            OFF_STATUS: DAT_O = pack_status(cnt9, fifo_full, fifo_empty, overflow_q);
            OFF_IRQ_EN: DAT_O = {31'b0, irq_en_rd};
            default:    DAT_O = '0;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= ST_IDLE;
            guard_q <= '0;
        end else begin
            state_q <= state_d;
            guard_q <= guard_d;
        end
    end

    always_comb begin
        state_d = state_q;
        guard_d = '0;
        case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = ST_POLL;
            ST_POLL:  if (U_ACK_I && U_DAT_I[LSR_TX_IDLE_BIT]) state_d = ST_WRITE;
            ST_WRITE: if (U_ACK_I) state_d = ST_GUARD;
            ST_GUARD: begin
                if (guard_q == GUARD_LAST) state_d = ST_IDLE;
                else                       guard_d = guard_q + 4'd1;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Bus outputs decode from state only, so reset drops the strobe without waiting for a clock.
    always_comb begin
        U_STB_O = 1'b0;
        U_WE_O  = 1'b0;
        U_ADD_O = '0;
        U_DAT_O = '0;
        case (state_q)
            ST_POLL: begin
                U_STB_O = 1'b1;
                U_ADD_O = OFF_UART_LSR;
            end
            ST_WRITE: begin
                U_STB_O = 1'b1;
                U_WE_O  = 1'b1;
                U_ADD_O = OFF_UART_DATA;
                U_DAT_O = {24'b0, head};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer with a small UART slave model that can stall polls/writes independently.
module tb_uart_tx_buffer;
    localparam int DEPTH_LOG2 = 4;
    localparam int GUARD_CYC  = 2;

    logic        CLK_I = 1'b0;
    logic        RST_I;
    logic [3:2]  ADD_I;
    logic [31:0] DAT_I;
    logic [31:0] DAT_O;
    logic        STB_I, WE_I, ACK_O;
    logic [4:2]  U_ADD_O;
    logic [31:0] U_DAT_O, U_DAT_I;
    logic        U_STB_O, U_WE_O, U_ACK_I, IRQ_O;

    uart_tx_buffer #(.DEPTH_LOG2(DEPTH_LOG2), .GUARD_CYC(GUARD_CYC)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .ADD_I(ADD_I), .DAT_I(DAT_I), .DAT_O(DAT_O),
        .STB_I(STB_I), .WE_I(WE_I), .ACK_O(ACK_O), .U_ADD_O(U_ADD_O), .U_DAT_O(U_DAT_O),
        .U_DAT_I(U_DAT_I), .U_STB_O(U_STB_O), .U_WE_O(U_WE_O), .U_ACK_I(U_ACK_I), .IRQ_O(IRQ_O)
    );

    always #5 CLK_I = ~CLK_I;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // UART slave: LSR reports tx-idle (bit5) once poll_cnt reaches poll_thr; bit0 is noise.
    logic ack_poll_en = 1'b0;
    logic ack_wr_en   = 1'b0;
    int   poll_cnt    = 0;
    int   poll_thr    = 0;
    logic [7:0] wr_q[$];
    int   polls_at_wr = 0;
    int   min_gap     = 1000;
    int   gap         = 0;
    bit   in_gap      = 0;
    bit   bad_wr      = 0;
    bit   irq_seen    = 0;

    assign U_ACK_I = U_STB_O && (U_WE_O ? ack_wr_en : ack_poll_en);
    assign U_DAT_I = (poll_cnt >= poll_thr) ? 32'h0000_0060 : 32'h0000_0001;

    always @(posedge CLK_I) begin
        if (U_STB_O && U_ACK_I && !U_WE_O) poll_cnt <= poll_cnt + 1;
        if (U_STB_O && U_ACK_I && U_WE_O) begin
            wr_q.push_back(U_DAT_O[7:0]);
            polls_at_wr = poll_cnt;
            if (U_ADD_O != 3'd0 || U_DAT_O[31:8] != 24'd0) bad_wr = 1;
            in_gap = 1;
            gap    = 0;
        end else if (in_gap) begin
            if (!U_STB_O) gap++;
            else begin
                if (gap < min_gap) min_gap = gap;
                in_gap = 0;
            end
        end
        if (IRQ_O) irq_seen = 1;
    end

    task automatic cpu_write(input logic [1:0] off, input logic [31:0] d);
        ADD_I = off; DAT_I = d; WE_I = 1'b1; STB_I = 1'b1;
        @(posedge CLK_I); #1;
        STB_I = 1'b0; WE_I = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] off, output logic [31:0] d, output logic a);
        ADD_I = off; WE_I = 1'b0; STB_I = 1'b1;
        #2;
        d = DAT_O; a = ACK_O;
        @(posedge CLK_I); #1;
        STB_I = 1'b0;
    endtask

    task automatic wait_wr(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && wr_q.size() < n; i++) @(posedge CLK_I);
        #1;
        chk(tag, wr_q.size(), n);
    endtask

    task automatic wait_wstate(input string tag);
        bit ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (U_STB_O && U_WE_O) ok = 1;
            else begin @(posedge CLK_I); #1; end
        end
        chk(tag, ok, 1);
    endtask

    logic [31:0] d;
    logic        a;
    int          base;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        RST_I = 1'b1; STB_I = 1'b0; WE_I = 1'b0; ADD_I = 2'd0; DAT_I = '0;
        repeat (2) @(posedge CLK_I);
        #1;
        chk("rst_stb", U_STB_O, 0);
        chk("rst_irq", IRQ_O, 0);
        RST_I = 1'b0;
        @(posedge CLK_I); #1;
        chk("ack_idle", ACK_O, 0);
        cpu_read(2'd1, d, a);
        chk("rst_status", d, 32'h2);
        chk("ack_comb", a, 1);
        cpu_write(2'd3, 32'hFFFF_FFFF);
        cpu_read(2'd3, d, a);
        chk("rsvd_rd", d, 0);
        cpu_read(2'd0, d, a);
        chk("data_rd", d, 0);

        // Three bytes drain in order with guard gaps.
        poll_thr = 0; ack_poll_en = 1; ack_wr_en = 1;
        cpu_write(2'd0, 32'h41);
        cpu_write(2'd0, 32'h42);
        cpu_write(2'd0, 32'h43);
        wait_wr("abc_cnt", 3, 200);
        chk("abc_0", wr_q[0], 8'h41);
        chk("abc_1", wr_q[1], 8'h42);
        chk("abc_2", wr_q[2], 8'h43);
        chk("guard_gap", (min_gap >= GUARD_CYC), 1);
        repeat (5) @(posedge CLK_I);
        #1;
        cpu_read(2'd1, d, a);
        chk("abc_empty", d, 32'h2);

        // Ten busy polls, then exactly one write on the eleventh.
        wr_q.delete();
        base = poll_cnt;
        poll_thr = poll_cnt + 10;
        cpu_write(2'd0, 32'h155);
        cpu_read(2'd1, d, a);
        chk("busy_cnt1", d, 32'h8);
        wait_wr("busy_wr", 1, 300);
        chk("busy_polls", polls_at_wr - base, 11);
        chk("busy_byte", wr_q[0], 8'h55);
        repeat (10) @(posedge CLK_I);
        #1;
        chk("busy_once", wr_q.size(), 1);
        cpu_read(2'd1, d, a);
        chk("busy_cnt0", d, 32'h2);

        // UART blocked: 17 pushes fill to 16 and overflow.
        ack_poll_en = 0; ack_wr_en = 0; poll_thr = 0;
        wr_q.delete();
        for (int i = 0; i < 17; i++) cpu_write(2'd0, 32'h60 + 32'(i));
        cpu_read(2'd1, d, a);
        chk("full_status", d, 32'h85);
        chk("poll_stb", U_STB_O, 1);
        chk("poll_we", U_WE_O, 0);
        chk("poll_add", U_ADD_O, 3'd5);
        @(posedge CLK_I); #1;
        chk("poll_hold_stb", U_STB_O, 1);
        chk("poll_hold_add", U_ADD_O, 3'd5);
        cpu_write(2'd1, 32'h1);
        cpu_read(2'd1, d, a);
        chk("ovf_clear", d, 32'h84);

        // Push coinciding with the write ack at count 16 is dropped.
        ack_poll_en = 1; ack_wr_en = 1;
        wait_wstate("wstate_full");
        cpu_write(2'd0, 32'hEE);
        cpu_read(2'd1, d, a);
        chk("drop_status", d, 32'h79);
        wait_wr("drain16", 16, 1000);
        for (int i = 0; i < 16; i++) chk("drain_order", wr_q[i], 8'h60 + 8'(i));
        cpu_write(2'd1, 32'h1);

        // Same collision at count 5: push and pop cancel.
        ack_poll_en = 0; ack_wr_en = 0;
        repeat (8) @(posedge CLK_I);
        #1;
        wr_q.delete();
        for (int i = 0; i < 5; i++) cpu_write(2'd0, 32'h80 + 32'(i));
        ack_poll_en = 1; ack_wr_en = 1;
        wait_wstate("wstate_5");
        cpu_write(2'd0, 32'h85);
        cpu_read(2'd1, d, a);
        chk("cnt5_status", d, 32'h28);
        wait_wr("drain6", 6, 600);
        for (int i = 0; i < 6; i++) chk("cnt5_order", wr_q[i], 8'h80 + 8'(i));
        chk("wr_addr_data", bad_wr, 0);

        // Reset in the middle of a stalled write.
        ack_poll_en = 1; ack_wr_en = 0;
        repeat (8) @(posedge CLK_I);
        #1;
        wr_q.delete();
        cpu_write(2'd0, 32'h99);
        wait_wstate("wstate_rst");
        chk("wr_dat", U_DAT_O, 32'h99);
        chk("wr_add", U_ADD_O, 3'd0);
        @(posedge CLK_I); #1;
        chk("wr_hold", U_STB_O, 1);
        #2;
        RST_I = 1'b1;
        #1;
        chk("rst_stb_async", U_STB_O, 0);
        chk("rst_we_async", U_WE_O, 0);
        @(posedge CLK_I); #1;
        RST_I = 1'b0;
        cpu_read(2'd1, d, a);
        chk("rst_mid_status", d, 32'h2);
        ack_wr_en = 1;
        repeat (20) @(posedge CLK_I);
        #1;
        chk("rst_discard", wr_q.size(), 0);

`ifdef UART_TXBUF_IRQ_EN
        cpu_write(2'd2, 32'h1);
        cpu_read(2'd2, d, a);
        chk("irq_en_rd", d, 1);
        chk("irq_idle", IRQ_O, 1);
        ack_poll_en = 1; ack_wr_en = 0;
        cpu_write(2'd0, 32'h31);
        wait_wstate("wstate_irq");
        chk("irq_busy", IRQ_O, 0);
        ack_wr_en = 1;
        @(posedge CLK_I); #1;
        chk("irq_pop_edge", IRQ_O, 0);
        @(posedge CLK_I); #1;
        chk("irq_next", IRQ_O, 1);
`else
        cpu_write(2'd2, 32'h1);
        cpu_read(2'd2, d, a);
        chk("irq_en_rd", d, 0);
        ack_poll_en = 1; ack_wr_en = 1;
        cpu_write(2'd0, 32'h31);
        wait_wr("irq_drain", 1, 200);
        repeat (5) @(posedge CLK_I);
        #1;
        chk("irq_never", irq_seen, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
